// File: rtl/jtag_dpram_bridge_if.sv
//------------------------------------------------------------------------------
// Module : jtag_dpram_bridge_if
// Brief  : Avalon-MM pipelined-read bus between the JTAG master and the bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface jtag_dpram_bridge_if;
    logic [31:0] iAVL_ADDRESS;
    logic        iAVL_READ;
    logic        iAVL_WRITE;
    logic [31:0] iAVL_WRITE_DATA;
    logic [4:0]  iAVL_BURST_COUNT;
    logic        oAVL_WAIT_REQUEST;
    logic [31:0] oAVL_READ_DATA;
    logic        oAVL_READ_DATAVALID;

    modport master (
        output iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA, iAVL_BURST_COUNT,
        input  oAVL_WAIT_REQUEST, oAVL_READ_DATA, oAVL_READ_DATAVALID
    );

    modport slave (
        input  iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA, iAVL_BURST_COUNT,
        output oAVL_WAIT_REQUEST, oAVL_READ_DATA, oAVL_READ_DATAVALID
    );
endinterface

`default_nettype wire

// File: rtl/jtag_dpram_bridge.sv
//------------------------------------------------------------------------------
// Module : jtag_dpram_bridge
// Brief  : Turns JTAG Avalon single/burst transfers into one-word-per-cycle
//          DPRAM accesses, with a window check at burst start.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtag_dpram_bridge #(
    parameter int          pADDR_W = 10,
    parameter logic [31:0] pBASE   = 32'h0000_0000
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    jtag_dpram_bridge_if.slave  avl,
    output logic                oDPRAM_CS,
    output logic [pADDR_W-1:0]  oDPRAM_ADDR,
    output logic                oDPRAM_WE,
    output logic [31:0]         oDPRAM_WDATA,
    input  logic [31:0]         iDPRAM_RDATA,
    output logic                oERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_RBURST = 2'd2,
        ST_RDRAIN = 2'd3
    } state_t;

    localparam logic [pADDR_W-1:0] c_PTR_ONE = {{(pADDR_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [pADDR_W-1:0]   ptr_q, ptr_d;
    logic [4:0]           rem_q, rem_d;
    logic                 hit_q, hit_d;
    logic                 cs_q, cs_d;
    logic                 we_q, we_d;
    logic [pADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 rd_issue_q, rd_issue_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_hit_q, rd_hit_d;
    logic                 wait_q, wait_d;
    logic                 err_q, err_d;

    logic [4:0]           w_burst_n;
    logic [pADDR_W-1:0]   w_word;
    logic                 w_hit;
    logic                 w_unused_addr_lsb;

    assign w_burst_n         = (avl.iAVL_BURST_COUNT == 5'd0) ? 5'd1 : avl.iAVL_BURST_COUNT;
    assign w_word            = avl.iAVL_ADDRESS[pADDR_W+1:2];
    assign w_hit             = (avl.iAVL_ADDRESS[31:pADDR_W+2] == pBASE[31:pADDR_W+2]);
    assign w_unused_addr_lsb = ^avl.iAVL_ADDRESS[1:0];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        hit_d      = hit_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_issue_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!wait_q) begin
                    if (avl.iAVL_WRITE) begin
                        // A simultaneous read is dropped; the write wins.
                        hit_d   = w_hit;
                        cs_d    = w_hit;
                        we_d    = w_hit;
                        addr_d  = w_word;
                        wdata_d = avl.iAVL_WRITE_DATA;
                        ptr_d   = w_word + c_PTR_ONE;
                        rem_d   = w_burst_n - 5'd1;
                        if (avl.iAVL_READ || !w_hit) err_d = 1'b1;
                        if (w_burst_n > 5'd1) state_d = ST_WBURST;
                    end else if (avl.iAVL_READ) begin
                        hit_d      = w_hit;
                        cs_d       = w_hit;
                        rd_issue_d = 1'b1;
                        addr_d     = w_word;
                        ptr_d      = w_word + c_PTR_ONE;
                        rem_d      = w_burst_n - 5'd1;
                        if (!w_hit) err_d = 1'b1;
                        state_d = ST_RBURST;
                    end
                end
            end
            ST_WBURST: begin
                if (avl.iAVL_WRITE) begin
                    cs_d    = hit_q;
                    we_d    = hit_q;
                    addr_d  = ptr_q;
                    wdata_d = avl.iAVL_WRITE_DATA;
                    ptr_d   = ptr_q + c_PTR_ONE;
                    rem_d   = rem_q - 5'd1;
                    if (rem_q == 5'd1) state_d = ST_IDLE;
                end
            end
            ST_RBURST: begin
                if (rem_q == 5'd0) begin
                    state_d = ST_RDRAIN;
                end else begin
                    cs_d       = hit_q;
                    rd_issue_d = 1'b1;
                    addr_d     = ptr_q;
                    ptr_d      = ptr_q + c_PTR_ONE;
                    rem_d      = rem_q - 5'd1;
                end
            end
            ST_RDRAIN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        wait_d     = (state_d == ST_RBURST) || (state_d == ST_RDRAIN);
        // DPRAM data arrives one cycle after the issue, so valid trails by one.
        rd_valid_d = rd_issue_q;
        rd_hit_d   = cs_q & ~we_q;
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            rem_q      <= 5'd0;
            hit_q      <= 1'b0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_issue_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            wait_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            hit_q      <= hit_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_issue_q <= rd_issue_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    assign oDPRAM_CS               = cs_q;
    assign oDPRAM_WE               = we_q;
    assign oDPRAM_ADDR             = addr_q;
    assign oDPRAM_WDATA            = wdata_q;
    assign oERR                    = err_q;
    assign avl.oAVL_WAIT_REQUEST   = wait_q;
    assign avl.oAVL_READ_DATAVALID = rd_valid_q;
    assign avl.oAVL_READ_DATA      = rd_hit_q ? iDPRAM_RDATA : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_jtag_dpram_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_jtag_dpram_bridge
// Brief  : Scoreboard bench for jtag_dpram_bridge with a behavioural DPRAM.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jtag_dpram_bridge;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dp_cs;
    logic              dp_we;
    logic [ADDR_W-1:0] dp_addr;
    logic [31:0]       dp_wdata;
    logic [31:0]       dp_rdata;
    logic              err;

    always #5 clk = ~clk;

    jtag_dpram_bridge_if avl();

    jtag_dpram_bridge #(.pADDR_W(ADDR_W), .pBASE(BASE)) dut (
        .iCLK         (clk),
        .iRESETn      (rst_n),
        .avl          (avl),
        .oDPRAM_CS    (dp_cs),
        .oDPRAM_ADDR  (dp_addr),
        .oDPRAM_WE    (dp_we),
        .oDPRAM_WDATA (dp_wdata),
        .iDPRAM_RDATA (dp_rdata),
        .oERR         (err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic [31:0] ram     [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    wr_t         wq[$];
    logic [31:0] rq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cs_cnt = 0;
    int          valid_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (dp_cs) begin
            if (dp_we) ram[dp_addr] <= dp_wdata;
            else       dp_rdata     <= ram[dp_addr];
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT produces a write or a datavalid beat.
    always begin
        wr_t e;
        logic [31:0] r;
        @(posedge clk);
        #1;
        if (dp_cs) cs_cnt++;
        if (dp_cs && dp_we) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL sb_write_unexpected: got addr=%h data=%h, want none", dp_addr, dp_wdata);
            end else begin
                e = wq.pop_front();
                if (dp_addr !== e.a || dp_wdata !== e.d) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%h data=%h, want addr=%h data=%h", dp_addr, dp_wdata, e.a, e.d);
                end
            end
        end
        if (avl.oAVL_READ_DATAVALID) begin
            valid_cnt++;
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL sb_read_unexpected: got data=%h, want no datavalid", avl.oAVL_READ_DATA);
            end else begin
                r = rq.pop_front();
                if (avl.oAVL_READ_DATA !== r) begin
                    bad++;
                    $display("FAIL sb_read: got data=%h, want %h", avl.oAVL_READ_DATA, r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        avl.iAVL_READ        = 1'b0;
        avl.iAVL_WRITE       = 1'b0;
        avl.iAVL_ADDRESS     = 32'h0;
        avl.iAVL_BURST_COUNT = 5'd0;
        avl.iAVL_WRITE_DATA  = 32'h0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (avl.oAVL_WAIT_REQUEST !== 1'b0 && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_ready: waitrequest got %b after %0d cycles, want 0", avl.oAVL_WAIT_REQUEST, g);
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input int n, input logic [31:0] d0);
        logic              hit;
        logic [ADDR_W-1:0] w;
        hit = (a[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
        wait_ready();
        for (int i = 0; i < n; i++) begin
            avl.iAVL_WRITE       = 1'b1;
            avl.iAVL_ADDRESS     = (i == 0) ? a : 32'h0;
            avl.iAVL_BURST_COUNT = 5'(n);
            avl.iAVL_WRITE_DATA  = d0 + 32'(i);
            w = a[ADDR_W+1:2] + ADDR_W'(i);
            if (hit) begin
                wq.push_back('{a: w, d: d0 + 32'(i)});
                ref_mem[w] = d0 + 32'(i);
            end
            tick();
        end
        idle_bus();
    endtask

    task automatic rd_burst(input logic [31:0] a, input int n, output int t);
        logic              hit;
        logic [ADDR_W-1:0] w;
        int                beats;
        hit   = (a[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
        beats = (n == 0) ? 1 : n;
        wait_ready();
        avl.iAVL_READ        = 1'b1;
        avl.iAVL_ADDRESS     = a;
        avl.iAVL_BURST_COUNT = 5'(n);
        for (int i = 0; i < beats; i++) begin
            w = a[ADDR_W+1:2] + ADDR_W'(i);
            rq.push_back(hit ? ref_mem[w] : 32'h0);
        end
        tick();
        t = cyc;
        idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (avl.oAVL_WAIT_REQUEST !== 1'b1 || dp_cs !== 1'b0 || dp_we !== 1'b0 || err !== 1'b0 ||
            avl.oAVL_READ_DATAVALID !== 1'b0 || avl.oAVL_READ_DATA !== 32'h0 || dp_addr !== '0 || dp_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_values: got wait=%b cs=%b we=%b err=%b dv=%b rd=%h addr=%h wd=%h, want 1,0,0,0,0,0,0,0",
                     avl.oAVL_WAIT_REQUEST, dp_cs, dp_we, err, avl.oAVL_READ_DATAVALID, avl.oAVL_READ_DATA, dp_addr, dp_wdata);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (avl.oAVL_WAIT_REQUEST !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_wait: got %b want 0", avl.oAVL_WAIT_REQUEST);
        end
    endtask

    task automatic test_single();
        int t;
        wait_ready();
        avl.iAVL_WRITE       = 1'b1;
        avl.iAVL_ADDRESS     = 32'h10;
        avl.iAVL_BURST_COUNT = 5'd1;
        avl.iAVL_WRITE_DATA  = 32'h1234_5678;
        wq.push_back('{a: 10'd4, d: 32'h1234_5678});
        ref_mem[4] = 32'h1234_5678;
        tick();
        idle_bus();
        total++;
        if (dp_cs !== 1'b1 || dp_we !== 1'b1 || dp_addr !== 10'd4 || dp_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_write: got cs=%b we=%b addr=%h data=%h, want 1 1 004 12345678", dp_cs, dp_we, dp_addr, dp_wdata);
        end
        rd_burst(32'h10, 1, t);
        total++;
        if (dp_cs !== 1'b1 || dp_we !== 1'b0 || dp_addr !== 10'd4 || avl.oAVL_READ_DATAVALID !== 1'b0 || avl.oAVL_WAIT_REQUEST !== 1'b1) begin
            bad++;
            $display("FAIL single_read_issue: got cs=%b we=%b addr=%h dv=%b wait=%b, want 1 0 004 0 1",
                     dp_cs, dp_we, dp_addr, avl.oAVL_READ_DATAVALID, avl.oAVL_WAIT_REQUEST);
        end
        tick();
        total++;
        if (avl.oAVL_READ_DATAVALID !== 1'b1 || avl.oAVL_READ_DATA !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_read_data: got dv=%b data=%h, want 1 12345678", avl.oAVL_READ_DATAVALID, avl.oAVL_READ_DATA);
        end
        tick();
        total++;
        if (avl.oAVL_READ_DATAVALID !== 1'b0 || avl.oAVL_WAIT_REQUEST !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL single_read_end: got dv=%b wait=%b err=%b, want 0 0 0", avl.oAVL_READ_DATAVALID, avl.oAVL_WAIT_REQUEST, err);
        end
    endtask

    task automatic test_wrap_stall();
        logic [4:0]        fl = 5'b11011;
        logic [ADDR_W-1:0] w;
        logic [31:0]       d;
        int                beat = 0;
        int                t;
        wait_ready();
        for (int c = 0; c < 5; c++) begin
            avl.iAVL_WRITE       = fl[c];
            avl.iAVL_ADDRESS     = (c == 0) ? 32'h0000_0FF8 : 32'h0;
            avl.iAVL_BURST_COUNT = 5'd4;
            d = 32'hA5A5_0000 + 32'(beat);
            avl.iAVL_WRITE_DATA  = d;
            w = 10'h3FE + ADDR_W'(beat);
            if (fl[c]) begin
                wq.push_back('{a: w, d: d});
                ref_mem[w] = d;
            end
            tick();
            total++;
            if (fl[c]) begin
                if (dp_cs !== 1'b1 || dp_we !== 1'b1 || dp_addr !== w) begin
                    bad++;
                    $display("FAIL wrap_beat%0d: got cs=%b we=%b addr=%h, want 1 1 %h", beat, dp_cs, dp_we, dp_addr, w);
                end
                beat++;
            end else if (dp_cs !== 1'b0) begin
                bad++;
                $display("FAIL wrap_stall: got cs=%b, want 0", dp_cs);
            end
        end
        idle_bus();
        rd_burst(32'h0000_0FF8, 4, t);
        total++;
        if (dp_cs !== 1'b1 || dp_we !== 1'b0 || dp_addr !== 10'h3FE) begin
            bad++;
            $display("FAIL wrap_idle_after: got cs=%b we=%b addr=%h, want 1 0 3fe", dp_cs, dp_we, dp_addr);
        end
        repeat (6) tick();
    endtask

    task automatic test_read16();
        int t;
        int t2;
        wr_burst(32'h0, 16, $urandom);
        rd_burst(32'h0, 16, t);
        for (int k = 1; k <= 17; k++) begin
            total++;
            if (avl.oAVL_WAIT_REQUEST !== 1'b1 || avl.oAVL_READ_DATAVALID !== (k >= 2)) begin
                bad++;
                $display("FAIL read16_cycle%0d: got wait=%b dv=%b, want 1 %b", k, avl.oAVL_WAIT_REQUEST, avl.oAVL_READ_DATAVALID, k >= 2);
            end
            tick();
        end
        total++;
        if (avl.oAVL_WAIT_REQUEST !== 1'b0 || avl.oAVL_READ_DATAVALID !== 1'b0) begin
            bad++;
            $display("FAIL read16_end: got wait=%b dv=%b, want 0 0", avl.oAVL_WAIT_REQUEST, avl.oAVL_READ_DATAVALID);
        end
        rd_burst(32'h8, 2, t2);
        total++;
        if (t2 !== t + 18) begin
            bad++;
            $display("FAIL read16_next_accept: got edge %0d, want %0d", t2, t + 18);
        end
        repeat (5) tick();
    endtask

    task automatic test_window();
        int t;
        int v0;
        int c0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL window_err_before: got %b want 0", err);
        end
        v0 = valid_cnt;
        c0 = cs_cnt;
        rd_burst(32'h0000_1000, 2, t);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL window_err_set: got %b want 1", err);
        end
        repeat (4) tick();
        total++;
        if (valid_cnt - v0 !== 2 || cs_cnt !== c0) begin
            bad++;
            $display("FAIL window_read: got beats=%0d cs=%0d, want 2 0", valid_cnt - v0, cs_cnt - c0);
        end
        wr_burst(32'h0000_2000, 2, 32'hDEAD_0000);
        repeat (2) tick();
        total++;
        if (cs_cnt !== c0 || err !== 1'b1 || avl.oAVL_WAIT_REQUEST !== 1'b0) begin
            bad++;
            $display("FAIL window_write: got cs=%0d err=%b wait=%b, want 0 1 0", cs_cnt - c0, err, avl.oAVL_WAIT_REQUEST);
        end
    endtask

    task automatic test_midreset();
        int t;
        int v0;
        int c0;
        wr_burst(32'h100, 8, $urandom);
        v0 = valid_cnt;
        rd_burst(32'h100, 8, t);
        repeat (3) tick();
        total++;
        if (err !== 1'b1 || avl.oAVL_READ_DATAVALID !== 1'b1) begin
            bad++;
            $display("FAIL midreset_before: got err=%b dv=%b, want 1 1", err, avl.oAVL_READ_DATAVALID);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (avl.oAVL_READ_DATAVALID !== 1'b0 || avl.oAVL_WAIT_REQUEST !== 1'b1 || dp_cs !== 1'b0 || avl.oAVL_READ_DATA !== 32'h0) begin
            bad++;
            $display("FAIL midreset_async: got dv=%b wait=%b cs=%b data=%h, want 0 1 0 0",
                     avl.oAVL_READ_DATAVALID, avl.oAVL_WAIT_REQUEST, dp_cs, avl.oAVL_READ_DATA);
        end
        total++;
        if (valid_cnt - v0 !== 3) begin
            bad++;
            $display("FAIL midreset_beats: got %0d beats before reset, want 3", valid_cnt - v0);
        end
        rq.delete();
        tick();
        total++;
        if (avl.oAVL_WAIT_REQUEST !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_hold: got wait=%b err=%b, want 1 0", avl.oAVL_WAIT_REQUEST, err);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (avl.oAVL_WAIT_REQUEST !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: got wait=%b want 0", avl.oAVL_WAIT_REQUEST);
        end
        c0 = cs_cnt;
        repeat (2) tick();
        total++;
        if (cs_cnt !== c0 || avl.oAVL_READ_DATAVALID !== 1'b0) begin
            bad++;
            $display("FAIL midreset_quiet: got cs=%0d dv=%b, want 0 0", cs_cnt - c0, avl.oAVL_READ_DATAVALID);
        end
        rd_burst(32'h104, 2, t);
        tick();
        total++;
        if (avl.oAVL_READ_DATAVALID !== 1'b1 || avl.oAVL_READ_DATA !== ref_mem[65]) begin
            bad++;
            $display("FAIL midreset_newread: got dv=%b data=%h, want 1 %h", avl.oAVL_READ_DATAVALID, avl.oAVL_READ_DATA, ref_mem[65]);
        end
        repeat (4) tick();
    endtask

    task automatic test_bc0_combined();
        int t;
        int v0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL bc0_err_before: got %b want 0", err);
        end
        wait_ready();
        avl.iAVL_WRITE       = 1'b1;
        avl.iAVL_ADDRESS     = 32'h20;
        avl.iAVL_BURST_COUNT = 5'd0;
        avl.iAVL_WRITE_DATA  = 32'hC0DE_0008;
        wq.push_back('{a: 10'd8, d: 32'hC0DE_0008});
        ref_mem[8] = 32'hC0DE_0008;
        tick();
        idle_bus();
        total++;
        if (dp_cs !== 1'b1 || dp_we !== 1'b1 || dp_addr !== 10'd8) begin
            bad++;
            $display("FAIL bc0_write: got cs=%b we=%b addr=%h, want 1 1 008", dp_cs, dp_we, dp_addr);
        end
        tick();
        total++;
        if (dp_cs !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL bc0_single: got cs=%b err=%b, want 0 0", dp_cs, err);
        end
        v0 = valid_cnt;
        avl.iAVL_WRITE       = 1'b1;
        avl.iAVL_READ        = 1'b1;
        avl.iAVL_ADDRESS     = 32'h24;
        avl.iAVL_BURST_COUNT = 5'd1;
        avl.iAVL_WRITE_DATA  = 32'hC0DE_0009;
        wq.push_back('{a: 10'd9, d: 32'hC0DE_0009});
        ref_mem[9] = 32'hC0DE_0009;
        tick();
        idle_bus();
        total++;
        if (dp_cs !== 1'b1 || dp_we !== 1'b1 || dp_addr !== 10'd9 || err !== 1'b1) begin
            bad++;
            $display("FAIL combined_write: got cs=%b we=%b addr=%h err=%b, want 1 1 009 1", dp_cs, dp_we, dp_addr, err);
        end
        repeat (3) tick();
        total++;
        if (valid_cnt !== v0 || avl.oAVL_WAIT_REQUEST !== 1'b0) begin
            bad++;
            $display("FAIL combined_no_read: got beats=%0d wait=%b, want 0 0", valid_cnt - v0, avl.oAVL_WAIT_REQUEST);
        end
        rd_burst(32'h20, 2, t);
        repeat (5) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        test_reset();
        test_single();
        test_wrap_stall();
        test_read16();
        test_window();
        test_midreset();
        test_bc0_combined();
        repeat (4) tick();
        total++;
        if (wq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got wq=%0d rq=%0d pending, want 0 0", wq.size(), rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jtag_dpram_bridge.md
# jtag_dpram_bridge

Bridges the JTAG-to-Avalon master in the MKR Vidor 4000 top level to the on-chip dual-port RAM (DPRAM) that the SAM D21 side also reads. The block consumes the JTAG bus (address, read/write, burst count, write data) and converts single and burst transfers into one-word-per-cycle DPRAM accesses. It returns read data with Avalon pipelined-read semantics, checks every burst against the DPRAM address window, and runs in the `wMEM_CLK` domain.

## Interface
- `pADDR_W`, 10: DPRAM word-address width; the window is 2^pADDR_W 32-bit words.
- `pBASE`, 32'h0000_0000: byte base address of the window; must be aligned to 2^(pADDR_W+2).
- `iCLK` in 1: the only clock; all logic is rising-edge.
- `iRESETn` in 1: reset, asynchronous and active-low.
- `iAVL_ADDRESS` in 32: byte address; bits [1:0] are ignored.
- `iAVL_READ` in 1: read request.
- `iAVL_WRITE` in 1: write request or write beat.
- `iAVL_WRITE_DATA` in 32: write data.
- `iAVL_BURST_COUNT` in 5: beats in the burst; 0 is treated as 1.
- `oAVL_WAIT_REQUEST` out 1: registered; a command or beat is accepted only on an edge where it is low.
- `oAVL_READ_DATA` out 32: read data.
- `oAVL_READ_DATAVALID` out 1: qualifies `oAVL_READ_DATA`.
- `oDPRAM_CS` out 1: DPRAM access strobe.
- `oDPRAM_ADDR` out pADDR_W: DPRAM word address.
- `oDPRAM_WE` out 1: write enable; valid only together with `oDPRAM_CS`.
- `oDPRAM_WDATA` out 32: write data to the DPRAM.
- `iDPRAM_RDATA` in 32: DPRAM read data; valid the cycle after a read with CS high and WE low.
- `oERR` out 1: sticky protocol/window error; cleared only by reset.

## Operation
- FSM states: IDLE, WBURST, RBURST, RDRAIN.
- IDLE:
  - `iAVL_WRITE` accepted: latch word address A = `iAVL_ADDRESS`[pADDR_W+1:2] and N = burst count (0→1). Write beat 0 to A in the same cycle.
  - If N>1, go to WBURST with remaining = N-1; otherwise stay in IDLE.
  - `iAVL_READ` accepted: latch A and N, then go to RBURST.
  - `iAVL_READ` and `iAVL_WRITE` both high: the write is taken, the read is dropped, and `oERR` is set.
- WBURST:
  - Every edge with `iAVL_WRITE`=1 writes the next beat to A+i.
  - Cycles with `iAVL_WRITE`=0 are stalls: no DPRAM access and no count change.
  - `iAVL_READ` is ignored.
  - After the last beat, return to IDLE.
- RBURST:
  - Issue one DPRAM read per cycle at A, A+1, … A+N-1 with no gaps.
  - After the last issue, go to RDRAIN.
- RDRAIN: one cycle, covering the final datavalid, then go to IDLE.
- Address arithmetic: A+i wraps modulo 2^pADDR_W. A burst never leaves the window.
- Window check, done once at burst start: `iAVL_ADDRESS`[31:pADDR_W+2] must equal `pBASE`[31:pADDR_W+2]. On a miss:
  - Set `oERR`.
  - Writes are consumed with normal handshake timing, but `oDPRAM_CS` stays low.
  - Reads produce N datavalid beats carrying 32'h0000_0000, with normal timing and no DPRAM access.
- `oAVL_WAIT_REQUEST` is 0 in IDLE and WBURST, and 1 in RBURST and RDRAIN.
- Reset, including mid-burst: FSM returns to IDLE and the burst is abandoned. No further beats or datavalid pulses are produced.
- Reset values:
  - `oAVL_WAIT_REQUEST`=1; it falls to 0 on the first edge after `iRESETn` rises.
  - All other outputs are 0.

## Timing
- Write: a beat accepted at edge E drives `oDPRAM_CS`=`oDPRAM_WE`=1 with the beat's address and data in the cycle after E. Write latency is 1, and throughput is 1 beat per cycle.
- Read: burst accepted at edge T.
  - DPRAM reads are issued in cycles T+1..T+N.
  - `oAVL_READ_DATAVALID`=1 in cycles T+2..T+N+1.
  - `oAVL_READ_DATA` = `iDPRAM_RDATA`, or 0 on a window miss, in those cycles.
  - `oAVL_WAIT_REQUEST` is 1 in cycles T+1..T+N+1 and 0 from T+N+2.
- Back-to-back: a new command may be accepted at edge T+N+2 after a read. After a write, a new command may be accepted on the edge following the last beat's edge.
- `oERR` is set one cycle after the offending edge.

## Test plan
- Reset, then single write 0x1234_5678 to byte 0x10, then single read of 0x10:
  - DPRAM word 4 is written one cycle after the write edge.
  - Datavalid occurs 2 cycles after read acceptance with data 0x1234_5678.
  - `oERR`=0.
- Write burst of 4 at byte 0xFF8 with pADDR_W=10, with one stall cycle after beat 1:
  - Words 0x3FE, 0x3FF, 0x000, 0x001 are written (wrap).
  - The stall produces no CS.
  - FSM is back in IDLE after beat 3.
- Read burst of 16 at 0x0:
  - Waitreq is high for 17 cycles.
  - 16 contiguous datavalid beats for words 0..15.
  - The next read is accepted at T+18.
- Read burst of 2 at 0x1000 (out of window):
  - Two beats of 0x0.
  - No DPRAM CS.
  - `oERR`=1 and stays 1 until reset.
- Burst count 0 write, plus a write with `iAVL_READ` high simultaneously:
  - The count-0 write is a single write.
  - The combined request performs the write only and sets `oERR`.
- `iRESETn` pulsed low during beat 3 of an 8-beat read:
  - Datavalid drops immediately, and waitreq is 1 during reset.
  - After release: waitreq is 0 on the first edge, and a new read works normally.
